// File: rtl/ethernet_receive_slot_manager_if.sv
// Slot-manager bus: parser strobes, slot offer, ready/release handshakes and event counters.
// The master side is the parser/consumer environment; the slave side is the slot manager.
interface ethernet_receive_slot_manager_if #(
    parameter int RECEIVE_QUE_SLOTS = 4,
    parameter int SLOT_INDEX_WIDTH  = $clog2(RECEIVE_QUE_SLOTS)
);
    logic [RECEIVE_QUE_SLOTS-1:0] packet_data_valid;
    logic [RECEIVE_QUE_SLOTS-1:0] good_packet;
    logic [RECEIVE_QUE_SLOTS-1:0] bad_packet;
    logic [RECEIVE_QUE_SLOTS-1:0] recieve_slot_enable;
    logic                         ready_valid;
    logic [SLOT_INDEX_WIDTH-1:0]  ready_slot;
    logic                         ready_accept;
    logic                         release_valid;
    logic [SLOT_INDEX_WIDTH-1:0]  release_slot;
    logic [SLOT_INDEX_WIDTH:0]    free_slot_count;
    logic [15:0]                  good_count;
    logic [15:0]                  bad_count;
    logic [15:0]                  timeout_count;

    modport master (
        output packet_data_valid, good_packet, bad_packet,
        output ready_accept, release_valid, release_slot,
        input  recieve_slot_enable, ready_valid, ready_slot,
        input  free_slot_count, good_count, bad_count, timeout_count
    );

    modport slave (
        input  packet_data_valid, good_packet, bad_packet,
        input  ready_accept, release_valid, release_slot,
        output recieve_slot_enable, ready_valid, ready_slot,
        output free_slot_count, good_count, bad_count, timeout_count
    );
endinterface

// File: rtl/ethernet_receive_slot_manager.sv
// Receive slot manager: offers one FREE slot at a time to the parser, queues completed
// slots in arrival order for the consumer and reclaims stalled or bad frames.
module ethernet_receive_slot_manager #(
    parameter int RECEIVE_QUE_SLOTS   = 4,
    parameter int FILL_TIMEOUT_CYCLES = 2048,
    parameter int SLOT_INDEX_WIDTH    = $clog2(RECEIVE_QUE_SLOTS)
) (
    input logic                            clock,
    input logic                            reset_n,
    ethernet_receive_slot_manager_if.slave bus
);
    localparam int              N          = RECEIVE_QUE_SLOTS;
    localparam int              SIW        = SLOT_INDEX_WIDTH;
    localparam logic [SIW:0]    SLOT_COUNT = (SIW+1)'(N);
    localparam logic [SIW-1:0]  LAST_INDEX = SIW'(N - 1);
    localparam logic [15:0]     TIMER_LAST = 16'(FILL_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        SLOT_FREE,
        SLOT_OFFERED,
        SLOT_FILLING,
        SLOT_READY,
        SLOT_DRAINING
    } slotState_t;

    slotState_t       r_slotState [N];
    slotState_t       w_nextState [N];
    logic [15:0]      r_fillTimer, w_nextFillTimer;
    logic [SIW-1:0]   r_fifoMem [N];
    logic [SIW-1:0]   r_fifoHead, r_fifoTail;
    logic [SIW:0]     r_fifoCount;
    logic [N-1:0]     r_slotEnable, w_slotEnable;
    logic [SIW:0]     r_freeCount, w_freeCount;
    logic [15:0]      r_goodCount, r_badCount, r_timeoutCount;
    logic             w_activeFound, w_freeFound;
    logic [SIW-1:0]   w_activeIdx, w_freeIdx, w_popIdx;
    logic             w_push, w_pop, w_releaseHit;
    logic             w_goodEvent, w_badEvent, w_timeoutEvent;

    function automatic logic [SIW-1:0] nextPtr(input logic [SIW-1:0] ptr);
        return (ptr == LAST_INDEX) ? '0 : ptr + SIW'(1);
    endfunction

    // Locate the slot owned by the parser and the lowest FREE slot, both from registered state.
    always_comb begin
        w_activeFound = 1'b0;
        w_activeIdx   = '0;
        w_freeFound   = 1'b0;
        w_freeIdx     = '0;
        for (int i = 0; i < N; i++) begin
            if (r_slotState[i] == SLOT_OFFERED || r_slotState[i] == SLOT_FILLING) begin
                w_activeFound = 1'b1;
                w_activeIdx   = SIW'(i);
            end
            if (!w_freeFound && r_slotState[i] == SLOT_FREE) begin
                w_freeFound = 1'b1;
                w_freeIdx   = SIW'(i);
            end
        end
    end

    assign w_pop        = (r_fifoCount != '0) && bus.ready_accept;
    assign w_popIdx     = r_fifoMem[r_fifoHead];
    assign w_releaseHit = bus.release_valid && ({1'b0, bus.release_slot} < SLOT_COUNT) &&
                          (r_slotState[bus.release_slot] == SLOT_DRAINING);

    // Next-state logic: bad beats good, good beats data, and only an idle FILLING slot ages.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_nextState[i] = r_slotState[i];
        end
        w_nextFillTimer = '0;
        w_push          = 1'b0;
        w_goodEvent     = 1'b0;
        w_badEvent      = 1'b0;
        w_timeoutEvent  = 1'b0;
        if (w_activeFound) begin
            case (r_slotState[w_activeIdx])
                SLOT_OFFERED: begin
                    if (bus.bad_packet[w_activeIdx]) begin
                        w_nextState[w_activeIdx] = SLOT_FREE;
                        w_badEvent               = 1'b1;
                    end else if (bus.packet_data_valid[w_activeIdx]) begin
                        w_nextState[w_activeIdx] = SLOT_FILLING;
                    end
                end
                SLOT_FILLING: begin
                    if (bus.bad_packet[w_activeIdx]) begin
                        w_nextState[w_activeIdx] = SLOT_FREE;
                        w_badEvent               = 1'b1;
                    end else if (bus.good_packet[w_activeIdx]) begin
                        w_nextState[w_activeIdx] = SLOT_READY;
                        w_push                   = 1'b1;
                        w_goodEvent              = 1'b1;
                    end else if (bus.packet_data_valid[w_activeIdx]) begin
                        w_nextFillTimer = '0;
                    end else if (r_fillTimer == TIMER_LAST) begin
                        w_nextState[w_activeIdx] = SLOT_FREE;
                        w_timeoutEvent           = 1'b1;
                    end else begin
                        w_nextFillTimer = r_fillTimer + 16'd1;
                    end
                end
                default: ;
            endcase
        end else if (w_freeFound) begin
            w_nextState[w_freeIdx] = SLOT_OFFERED;
        end
        if (w_pop) begin
            w_nextState[w_popIdx] = SLOT_DRAINING;
        end
        if (w_releaseHit) begin
            w_nextState[bus.release_slot] = SLOT_FREE;
        end
    end

    // Output decode; the enable lags the owning slot's state by one registered stage.
    always_comb begin
        w_slotEnable = '0;
        w_freeCount  = '0;
        for (int i = 0; i < N; i++) begin
            if (r_slotState[i] == SLOT_OFFERED || r_slotState[i] == SLOT_FILLING) begin
                w_slotEnable[i] = 1'b1;
            end
            if (w_nextState[i] == SLOT_FREE) begin
                w_freeCount = w_freeCount + (SIW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                r_slotState[i] <= SLOT_FREE;
            end
            r_fillTimer  <= '0;
            r_slotEnable <= '0;
            r_freeCount  <= SLOT_COUNT;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_slotState[i] <= w_nextState[i];
            end
            r_fillTimer  <= w_nextFillTimer;
            r_slotEnable <= w_slotEnable;
            r_freeCount  <= w_freeCount;
        end
    end

    // Ready FIFO never overflows: it can only hold slots that are in READY.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                r_fifoMem[i] <= '0;
            end
            r_fifoHead  <= '0;
            r_fifoTail  <= '0;
            r_fifoCount <= '0;
        end else begin
            if (w_push) begin
                r_fifoMem[r_fifoTail] <= w_activeIdx;
                r_fifoTail            <= nextPtr(r_fifoTail);
            end
            if (w_pop) begin
                r_fifoHead <= nextPtr(r_fifoHead);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifoCount <= r_fifoCount + (SIW+1)'(1);
                2'b01:   r_fifoCount <= r_fifoCount - (SIW+1)'(1);
                default: r_fifoCount <= r_fifoCount;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_goodCount    <= '0;
            r_badCount     <= '0;
            r_timeoutCount <= '0;
        end else begin
            if (w_goodEvent && r_goodCount != 16'hFFFF) begin
                r_goodCount <= r_goodCount + 16'd1;
            end
            if (w_badEvent && r_badCount != 16'hFFFF) begin
                r_badCount <= r_badCount + 16'd1;
            end
            if (w_timeoutEvent && r_timeoutCount != 16'hFFFF) begin
                r_timeoutCount <= r_timeoutCount + 16'd1;
            end
        end
    end

    assign bus.recieve_slot_enable = r_slotEnable;
    assign bus.ready_valid         = (r_fifoCount != '0);
    assign bus.ready_slot          = (r_fifoCount != '0) ? r_fifoMem[r_fifoHead] : '0;
    assign bus.free_slot_count     = r_freeCount;
    assign bus.good_count          = r_goodCount;
    assign bus.bad_count           = r_badCount;
    assign bus.timeout_count       = r_timeoutCount;
endmodule

// File: tb/tb_ethernet_receive_slot_manager.sv
// Bench for the receive slot manager: directed scenarios followed by random traffic,
// every cycle compared against a slot/queue level reference model.
module tb_ethernet_receive_slot_manager;
    localparam int SLOTS   = 4;
    localparam int TIMEOUT = 8;

    typedef enum int {M_FREE, M_OFFERED, M_FILLING, M_READY, M_DRAINING} modelSlot_t;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    int         checkCount = 0;
    int         errorCount = 0;
    modelSlot_t mSlot [SLOTS];
    int         readyQ [$];
    int         idleCycles;
    int         mGood, mBad, mTimeout;
    logic [3:0] mEnable;

    ethernet_receive_slot_manager_if #(.RECEIVE_QUE_SLOTS(SLOTS)) dutIf ();

    ethernet_receive_slot_manager #(
        .RECEIVE_QUE_SLOTS  (SLOTS),
        .FILL_TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (dutIf.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach its end, limit 500000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [3:0] oneHot(input int idx);
        return 4'(1 << idx);
    endfunction

    function automatic int bump(input int value);
        return (value < 65535) ? value + 1 : 65535;
    endfunction

    function automatic int modelFree();
        int n = 0;
        for (int i = 0; i < SLOTS; i++) begin
            if (mSlot[i] == M_FREE) n++;
        end
        return n;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < SLOTS; i++) mSlot[i] = M_FREE;
        readyQ.delete();
        idleCycles = 0;
        mGood      = 0;
        mBad       = 0;
        mTimeout   = 0;
        mEnable    = 4'b0;
    endtask

    // One clock edge of the slot life cycle, decided from the state before the edge.
    task automatic modelEdge(input logic [3:0] v, g, b, input logic acc, rel, input logic [1:0] relSlot);
        int         owner;
        int         head;
        modelSlot_t nxt [SLOTS];
        owner = -1;
        for (int i = 0; i < SLOTS; i++) begin
            nxt[i] = mSlot[i];
            if (mSlot[i] == M_OFFERED || mSlot[i] == M_FILLING) owner = i;
        end
        mEnable = (owner >= 0) ? oneHot(owner) : 4'b0;
        if (acc && readyQ.size() > 0) begin
            head      = readyQ.pop_front();
            nxt[head] = M_DRAINING;
        end
        if (rel && mSlot[relSlot] == M_DRAINING) nxt[relSlot] = M_FREE;
        if (owner >= 0) begin
            if (b[owner]) begin
                nxt[owner] = M_FREE;
                mBad       = bump(mBad);
                idleCycles = 0;
            end else if (mSlot[owner] == M_OFFERED) begin
                if (v[owner]) begin
                    nxt[owner] = M_FILLING;
                    idleCycles = 0;
                end
            end else if (g[owner]) begin
                nxt[owner] = M_READY;
                readyQ.push_back(owner);
                mGood      = bump(mGood);
                idleCycles = 0;
            end else if (v[owner]) begin
                idleCycles = 0;
            end else begin
                idleCycles++;
                if (idleCycles >= TIMEOUT) begin
                    nxt[owner] = M_FREE;
                    mTimeout   = bump(mTimeout);
                    idleCycles = 0;
                end
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (mSlot[i] == M_FREE) begin
                    nxt[i] = M_OFFERED;
                    break;
                end
            end
        end
        for (int i = 0; i < SLOTS; i++) mSlot[i] = nxt[i];
    endtask

    task automatic checkModel();
        checkOutput("enable", 32'(dutIf.recieve_slot_enable), 32'(mEnable));
        checkOutput("readyValid", 32'(dutIf.ready_valid), 32'(readyQ.size() != 0));
        checkOutput("readySlot", 32'(dutIf.ready_slot), 32'((readyQ.size() != 0) ? readyQ[0] : 0));
        checkOutput("freeCount", 32'(dutIf.free_slot_count), 32'(modelFree()));
        checkOutput("goodCount", 32'(dutIf.good_count), 32'(mGood));
        checkOutput("badCount", 32'(dutIf.bad_count), 32'(mBad));
        checkOutput("timeoutCount", 32'(dutIf.timeout_count), 32'(mTimeout));
    endtask

    task automatic applyStimulus(input logic [3:0] v, g, b, input logic acc, rel, input logic [1:0] relSlot);
        dutIf.packet_data_valid = v;
        dutIf.good_packet       = g;
        dutIf.bad_packet        = b;
        dutIf.ready_accept      = acc;
        dutIf.release_valid     = rel;
        dutIf.release_slot      = relSlot;
        @(posedge clock);
        modelEdge(v, g, b, acc, rel, relSlot);
        #1;
        checkModel();
    endtask

    task automatic idleTick();
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic dataTick(input int idx);
        applyStimulus(oneHot(idx), 4'b0, 4'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic waitOffer(input int idx);
        for (int t = 0; t < 12; t++) begin
            if (dutIf.recieve_slot_enable == oneHot(idx)) break;
            idleTick();
        end
        checkOutput($sformatf("offer%0d", idx), 32'(dutIf.recieve_slot_enable), 32'(oneHot(idx)));
    endtask

    task automatic fillGood(input int idx, input int beats);
        waitOffer(idx);
        for (int n = 0; n < beats; n++) dataTick(idx);
        applyStimulus(4'b0, oneHot(idx), 4'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic doReset();
        dutIf.packet_data_valid = 4'b0;
        dutIf.good_packet       = 4'b0;
        dutIf.bad_packet        = 4'b0;
        dutIf.ready_accept      = 1'b0;
        dutIf.release_valid     = 1'b0;
        dutIf.release_slot      = 2'd0;
        reset_n = 1'b0;
        #1;
        checkOutput("rstEnable", 32'(dutIf.recieve_slot_enable), 32'd0);
        checkOutput("rstReadyValid", 32'(dutIf.ready_valid), 32'd0);
        checkOutput("rstReadySlot", 32'(dutIf.ready_slot), 32'd0);
        checkOutput("rstFree", 32'(dutIf.free_slot_count), 32'd4);
        checkOutput("rstGood", 32'(dutIf.good_count), 32'd0);
        checkOutput("rstBad", 32'(dutIf.bad_count), 32'd0);
        checkOutput("rstTimeout", 32'(dutIf.timeout_count), 32'd0);
        modelReset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic randomTick(input int validPct);
        logic [3:0] en, v, g, b, offeredMask;
        en          = dutIf.recieve_slot_enable;
        offeredMask = 4'b0;
        for (int i = 0; i < SLOTS; i++) offeredMask[i] = (mSlot[i] == M_OFFERED);
        v = (int'($urandom_range(0, 99)) < validPct) ? en : 4'b0;
        if ($urandom_range(0, 99) < 3) v = v | oneHot(int'($urandom_range(0, 3)));
        g = ($urandom_range(0, 99) < 10) ? en : 4'b0;
        if ($urandom_range(0, 99) < 2) g = g | oneHot(int'($urandom_range(0, 3)));
        g = g & ~offeredMask;
        b = 4'b0;
        if ($urandom_range(0, 99) < 3) b = ($urandom_range(0, 1) == 0) ? en : oneHot(int'($urandom_range(0, 3)));
        applyStimulus(v, g, b, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 40,
                      2'($urandom_range(0, 3)));
    endtask

    initial begin
        #2;
        doReset();

        // First offer appears on the second edge after reset release.
        idleTick();
        checkOutput("firstEdgeEnable", 32'(dutIf.recieve_slot_enable), 32'd0);
        checkOutput("offeredFree", 32'(dutIf.free_slot_count), 32'd3);
        idleTick();
        checkOutput("secondEdgeEnable", 32'(dutIf.recieve_slot_enable), 32'b0001);

        fillGood(0, 10);
        checkOutput("slot0ReadyValid", 32'(dutIf.ready_valid), 32'd1);
        checkOutput("slot0ReadySlot", 32'(dutIf.ready_slot), 32'd0);
        checkOutput("slot0Good", 32'(dutIf.good_count), 32'd1);
        idleTick();
        idleTick();
        checkOutput("nextOffer1", 32'(dutIf.recieve_slot_enable), 32'b0010);

        fillGood(1, 3);
        fillGood(2, 3);
        fillGood(3, 3);
        idleTick();
        idleTick();
        checkOutput("allReadyEnable", 32'(dutIf.recieve_slot_enable), 32'd0);
        checkOutput("allReadyFree", 32'(dutIf.free_slot_count), 32'd0);

        repeat (3) applyStimulus(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 2'd2);
        idleTick();
        idleTick();
        checkOutput("reofferSlot2", 32'(dutIf.recieve_slot_enable), 32'b0100);
        checkOutput("headAfterPops", 32'(dutIf.ready_slot), 32'd3);
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 2'd0);
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 2'd1);
        fillGood(2, 2);

        // Fill timeout: the eighth idle edge after the last byte reclaims the slot.
        waitOffer(0);
        repeat (3) dataTick(0);
        repeat (7) idleTick();
        checkOutput("timeoutEarly", 32'(dutIf.timeout_count), 32'd0);
        idleTick();
        checkOutput("timeoutHit", 32'(dutIf.timeout_count), 32'd1);
        idleTick();
        idleTick();
        checkOutput("timeoutReoffer", 32'(dutIf.recieve_slot_enable), 32'b0001);
        dataTick(0);
        applyStimulus(4'b0, 4'b0001, 4'b0, 1'b0, 1'b0, 2'd0);

        waitOffer(1);
        dataTick(1);
        applyStimulus(4'b0, 4'b0010, 4'b0010, 1'b0, 1'b0, 2'd0);
        checkOutput("goodBadBad", 32'(dutIf.bad_count), 32'd1);
        checkOutput("goodBadGood", 32'(dutIf.good_count), 32'd6);
        checkOutput("goodBadHead", 32'(dutIf.ready_slot), 32'd3);
        waitOffer(1);
        dataTick(1);

        // Reset in the middle of a frame discards everything.
        doReset();
        idleTick();
        checkOutput("midResetEdge1", 32'(dutIf.recieve_slot_enable), 32'd0);
        idleTick();
        checkOutput("midResetEdge2", 32'(dutIf.recieve_slot_enable), 32'b0001);

        fillGood(0, 2);
        fillGood(1, 2);
        fillGood(2, 2);
        waitOffer(3);
        dataTick(3);
        applyStimulus(4'b0, 4'b1000, 4'b0, 1'b1, 1'b0, 2'd0);
        checkOutput("pushPopHead", 32'(dutIf.ready_slot), 32'd1);
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
        checkOutput("orderHead2", 32'(dutIf.ready_slot), 32'd2);
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
        checkOutput("orderHead3", 32'(dutIf.ready_slot), 32'd3);
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
        checkOutput("orderEmpty", 32'(dutIf.ready_valid), 32'd0);
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 2'd0);
        idleTick();
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 2'd1);
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 2'd1);
        checkOutput("releaseFreeIgnored", 32'(dutIf.free_slot_count), 32'd1);

        for (int blk = 0; blk < 10; blk++) begin
            int pct;
            pct = int'($urandom_range(5, 95));
            for (int n = 0; n < 200; n++) randomTick(pct);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
